// File: rtl/m_memarb_if.sv
// Bus bundle between the memory arbiter, its three requesters and the memory.
// slave  : arbiter side (sees requests and memory read data, drives grants and memory controls)
// master : environment side (core/loader requesters plus the memory instance)
interface m_memarb_if #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 32
);
    // requester side: data (d), instruction fetch (i), loader/debug (l)
    logic              w_d_req;
    logic              w_i_req;
    logic              w_l_req;
    logic              w_d_we;
    logic              w_l_we;
    logic [ADDR_W-1:0] w_d_addr;
    logic [ADDR_W-1:0] w_i_addr;
    logic [ADDR_W-1:0] w_l_addr;
    logic [DATA_W-1:0] w_d_din;
    logic [DATA_W-1:0] w_l_din;
    logic              w_d_gnt;
    logic              w_i_gnt;
    logic              w_l_gnt;
    logic              r_d_rvalid;
    logic              r_i_rvalid;
    logic              r_l_rvalid;
    logic [DATA_W-1:0] w_rdata;

    // memory side
    logic [ADDR_W-1:0] w_m_addr;
    logic              w_m_we;
    logic [DATA_W-1:0] w_m_din;
    logic [DATA_W-1:0] w_m_dout;

    modport slave (
        input  w_d_req, w_i_req, w_l_req,
        input  w_d_we, w_l_we,
        input  w_d_addr, w_i_addr, w_l_addr,
        input  w_d_din, w_l_din,
        output w_d_gnt, w_i_gnt, w_l_gnt,
        output r_d_rvalid, r_i_rvalid, r_l_rvalid,
        output w_rdata,
        output w_m_addr, w_m_we, w_m_din,
        input  w_m_dout
    );

    modport master (
        output w_d_req, w_i_req, w_l_req,
        output w_d_we, w_l_we,
        output w_d_addr, w_i_addr, w_l_addr,
        output w_d_din, w_l_din,
        input  w_d_gnt, w_i_gnt, w_l_gnt,
        input  r_d_rvalid, r_i_rvalid, r_l_rvalid,
        input  w_rdata,
        input  w_m_addr, w_m_we, w_m_din,
        output w_m_dout
    );
endinterface

// File: rtl/m_memarb.sv
// Three-port arbiter sharing one synchronous single-port memory between the
// MEM-stage data port (D), the IF-stage fetch port (I) and the loader (L).
// Fixed priority D > I > L, with starvation promotion: a port denied STARVE
// consecutive cycles becomes urgent and wins over non-urgent ports.
// Ports:
//   w_clk, w_rst : clock, asynchronous active-high reset
//   bus (slave)  : requests/grants/read-valids per port, read data, memory drive
module m_memarb #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned STARVE = 8
) (
    input  logic       w_clk,
    input  logic       w_rst,
    m_memarb_if.slave  bus
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE);

    logic [CNT_W-1:0]  cnt_d;
    logic [CNT_W-1:0]  cnt_i;
    logic [CNT_W-1:0]  cnt_l;
    logic              urg_d;
    logic              urg_i;
    logic              urg_l;
    logic              gnt_d;
    logic              gnt_i;
    logic              gnt_l;
    logic              any_gnt;
    logic [ADDR_W-1:0] last_addr;
    logic [ADDR_W-1:0] m_addr;
    logic              m_we;
    logic [DATA_W-1:0] m_din;
    logic              rv_d;
    logic              rv_i;
    logic              rv_l;

    // Wait counter next value: clear on grant or idle, otherwise count up and hold at STARVE.
    function automatic logic [CNT_W-1:0] cnt_next(
        input logic             req,
        input logic             gnt,
        input logic [CNT_W-1:0] cnt
    );
        if (!req || gnt) begin
            return '0;
        end
        if (cnt == CNT_MAX) begin
            return cnt;
        end
        return cnt + CNT_W'(1);
    endfunction

    // Selection: urgent requesters first (in base order), then plain base priority.
    always_comb begin
        urg_d = bus.w_d_req && (cnt_d == CNT_MAX);
        urg_i = bus.w_i_req && (cnt_i == CNT_MAX);
        urg_l = bus.w_l_req && (cnt_l == CNT_MAX);
        gnt_d = 1'b0;
        gnt_i = 1'b0;
        gnt_l = 1'b0;
        if (!w_rst) begin
            if (urg_d) begin
                gnt_d = 1'b1;
            end else if (urg_i) begin
                gnt_i = 1'b1;
            end else if (urg_l) begin
                gnt_l = 1'b1;
            end else if (bus.w_d_req) begin
                gnt_d = 1'b1;
            end else if (bus.w_i_req) begin
                gnt_i = 1'b1;
            end else if (bus.w_l_req) begin
                gnt_l = 1'b1;
            end
        end
    end

    assign any_gnt = gnt_d | gnt_i | gnt_l;

    // Memory drive mux; when idle the address parks on the last granted one.
    always_comb begin
        m_addr = last_addr;
        m_we   = 1'b0;
        m_din  = '0;
        if (gnt_d) begin
            m_addr = bus.w_d_addr;
            m_we   = bus.w_d_we;
            m_din  = bus.w_d_din;
        end else if (gnt_i) begin
            m_addr = bus.w_i_addr;
        end else if (gnt_l) begin
            m_addr = bus.w_l_addr;
            m_we   = bus.w_l_we;
            m_din  = bus.w_l_din;
        end
    end

    // Wait counters, read-valid pulses and parked address.
    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            cnt_d     <= '0;
            cnt_i     <= '0;
            cnt_l     <= '0;
            rv_d      <= 1'b0;
            rv_i      <= 1'b0;
            rv_l      <= 1'b0;
            last_addr <= '0;
        end else begin
            cnt_d <= cnt_next(bus.w_d_req, gnt_d, cnt_d);
            cnt_i <= cnt_next(bus.w_i_req, gnt_i, cnt_i);
            cnt_l <= cnt_next(bus.w_l_req, gnt_l, cnt_l);
            // memory returns data one cycle after a granted read
            rv_d  <= gnt_d & ~bus.w_d_we;
            rv_i  <= gnt_i;
            rv_l  <= gnt_l & ~bus.w_l_we;
            if (any_gnt) begin
                last_addr <= m_addr;
            end
        end
    end

    assign bus.w_d_gnt    = gnt_d;
    assign bus.w_i_gnt    = gnt_i;
    assign bus.w_l_gnt    = gnt_l;
    assign bus.r_d_rvalid = rv_d;
    assign bus.r_i_rvalid = rv_i;
    assign bus.r_l_rvalid = rv_l;
    assign bus.w_rdata    = bus.w_m_dout;
    assign bus.w_m_addr   = m_addr;
    assign bus.w_m_we     = m_we;
    assign bus.w_m_din    = m_din;

    // Grants and read-valids are each one-hot or idle.
    a_gnt_onehot : assert property (@(posedge w_clk) disable iff (w_rst)
        $onehot0({gnt_d, gnt_i, gnt_l}));
    a_rv_onehot : assert property (@(posedge w_clk) disable iff (w_rst)
        $onehot0({rv_d, rv_i, rv_l}));

endmodule

// File: tb/tb_m_memarb.sv
// Self-checking bench for m_memarb: behavioural memory, reference arbitration
// model and a read-return scoreboard.
module tb_m_memarb;

    localparam int unsigned ADDR_W = 12;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STARVE = 8;
    localparam int unsigned DEPTH  = 4096;

    typedef struct packed {
        logic [2:0]        port;
        logic [DATA_W-1:0] data;
    } exp_t;

    logic w_clk = 1'b0;
    logic w_rst = 1'b0;

    m_memarb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    m_memarb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE(STARVE)) dut (
        .w_clk (w_clk),
        .w_rst (w_rst),
        .bus   (bus)
    );

    always #5 w_clk = ~w_clk;

    function automatic logic [DATA_W-1:0] init_word(input int a);
        if (a == 5) return 32'h2014000B;
        return 32'h5A000000 ^ (32'(a) * 32'h00010003);
    endfunction

    // Behavioural synchronous memory (1-cycle read, write at edge).
    logic [DATA_W-1:0] mem [0:DEPTH-1];
    logic              mem_ready = 1'b0;
    always @(posedge w_clk) begin
        if (!mem_ready) begin
            for (int a = 0; a < int'(DEPTH); a++) mem[a] <= init_word(a);
            mem_ready <= 1'b1;
        end else begin
            if (bus.w_m_we) mem[bus.w_m_addr] <= bus.w_m_din;
            bus.w_m_dout <= mem[bus.w_m_addr];
        end
    end

    // Reference state
    logic [DATA_W-1:0] ref_mem [0:DEPTH-1];
    int unsigned       mc [3];
    logic [ADDR_W-1:0] m_last;
    exp_t              sbq [$];
    int                total = 0;
    int                bad   = 0;
    logic [2:0]        ep;
    logic [DATA_W-1:0] ed;
    logic [2:0]        eg;

    function automatic logic [2:0] req_vec();
        return {bus.w_l_req, bus.w_i_req, bus.w_d_req};
    endfunction
    function automatic logic [2:0] gnt_vec();
        return {bus.w_l_gnt, bus.w_i_gnt, bus.w_d_gnt};
    endfunction
    function automatic logic [2:0] rv_vec();
        return {bus.r_l_rvalid, bus.r_i_rvalid, bus.r_d_rvalid};
    endfunction

    // Expected grant from the reference counters and current requests.
    function automatic logic [2:0] model_gnt();
        logic [2:0] r;
        logic [2:0] u;
        r = req_vec();
        for (int k = 0; k < 3; k++) u[k] = r[k] && (mc[k] == STARVE);
        if (u[0]) return 3'b001;
        if (u[1]) return 3'b010;
        if (u[2]) return 3'b100;
        if (r[0]) return 3'b001;
        if (r[1]) return 3'b010;
        if (r[2]) return 3'b100;
        return 3'b000;
    endfunction

    // Advance the reference model across one clock edge; queue expected reads.
    task automatic tick_model();
        logic [2:0] g;
        logic [2:0] r;
        g = model_gnt();
        r = req_vec();
        for (int k = 0; k < 3; k++) begin
            if (!r[k] || g[k]) mc[k] = 0;
            else if (mc[k] < STARVE) mc[k] = mc[k] + 1;
        end
        if (g[0]) begin
            m_last = bus.w_d_addr;
            if (bus.w_d_we) ref_mem[bus.w_d_addr] = bus.w_d_din;
            else sbq.push_back('{port: 3'b001, data: ref_mem[bus.w_d_addr]});
        end
        if (g[1]) begin
            m_last = bus.w_i_addr;
            sbq.push_back('{port: 3'b010, data: ref_mem[bus.w_i_addr]});
        end
        if (g[2]) begin
            m_last = bus.w_l_addr;
            if (bus.w_l_we) ref_mem[bus.w_l_addr] = bus.w_l_din;
            else sbq.push_back('{port: 3'b100, data: ref_mem[bus.w_l_addr]});
        end
    endtask

    task automatic sb_next(output logic [2:0] p, output logic [DATA_W-1:0] d);
        exp_t e;
        if (sbq.size() != 0) begin
            e = sbq.pop_front();
            p = e.port;
            d = e.data;
        end else begin
            p = 3'b000;
            d = '0;
        end
    endtask

    task automatic idle_inputs();
        bus.w_d_req = 1'b0; bus.w_i_req = 1'b0; bus.w_l_req = 1'b0;
        bus.w_d_we  = 1'b0; bus.w_l_we  = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        bus.w_d_addr = '0; bus.w_i_addr = '0; bus.w_l_addr = '0;
        bus.w_d_din  = '0; bus.w_l_din  = '0;
        bus.w_d_req  = 1'b1;
        #1 w_rst = 1'b1;
        #1;
        total++; if (gnt_vec() !== 3'b000) begin bad++; $display("FAIL reset_gnt got=%b want=000", gnt_vec()); end
        total++; if (rv_vec() !== 3'b000) begin bad++; $display("FAIL reset_rvalid got=%b want=000", rv_vec()); end
        total++; if (bus.w_m_we !== 1'b0) begin bad++; $display("FAIL reset_m_we got=%b want=0", bus.w_m_we); end
        total++; if ({dut.cnt_d, dut.cnt_i, dut.cnt_l} !== 12'h000) begin bad++; $display("FAIL reset_cnt got=%h want=000", {dut.cnt_d, dut.cnt_i, dut.cnt_l}); end
        total++; if (bus.w_m_addr !== 12'h000) begin bad++; $display("FAIL reset_m_addr got=%h want=000", bus.w_m_addr); end
        @(negedge w_clk);
        w_rst = 1'b0;
        bus.w_d_req = 1'b0;
        @(posedge w_clk); #1;
    endtask

    task automatic test_single_read();
        bus.w_i_req = 1'b1; bus.w_i_addr = 12'h005;
        @(negedge w_clk);
        total++; if (gnt_vec() !== 3'b010) begin bad++; $display("FAIL single_gnt got=%b want=010", gnt_vec()); end
        sb_next(ep, ed);
        total++; if (rv_vec() !== ep) begin bad++; $display("FAIL single_rv0 got=%b want=%b", rv_vec(), ep); end
        tick_model();
        @(posedge w_clk); #1;
        bus.w_i_req = 1'b0;
        @(negedge w_clk);
        total++; if (gnt_vec() !== 3'b000) begin bad++; $display("FAIL single_gnt_idle got=%b want=000", gnt_vec()); end
        sb_next(ep, ed);
        total++; if (rv_vec() !== ep || (ep != 3'b000 && bus.w_rdata !== ed)) begin bad++; $display("FAIL single_rv got=%b/%h want=%b/%h", rv_vec(), bus.w_rdata, ep, ed); end
        total++; if (rv_vec() !== 3'b010 || bus.w_rdata !== 32'h2014000B) begin bad++; $display("FAIL single_data got=%b/%h want=010/2014000b", rv_vec(), bus.w_rdata); end
        tick_model();
        @(posedge w_clk); #1;
        @(negedge w_clk);
        sb_next(ep, ed);
        total++; if (rv_vec() !== ep) begin bad++; $display("FAIL single_rv_end got=%b want=%b", rv_vec(), ep); end
        tick_model();
        @(posedge w_clk); #1;
    endtask

    task automatic test_write_read();
        bus.w_d_req = 1'b1; bus.w_d_we = 1'b1; bus.w_d_addr = 12'h010; bus.w_d_din = 32'h00000007;
        @(negedge w_clk);
        total++; if (gnt_vec() !== 3'b001) begin bad++; $display("FAIL wr_gnt got=%b want=001", gnt_vec()); end
        total++; if (bus.w_m_we !== 1'b1 || bus.w_m_addr !== 12'h010 || bus.w_m_din !== 32'h7) begin bad++; $display("FAIL wr_drive got=%b/%h/%h want=1/010/00000007", bus.w_m_we, bus.w_m_addr, bus.w_m_din); end
        sb_next(ep, ed);
        total++; if (rv_vec() !== ep) begin bad++; $display("FAIL wr_rv got=%b want=%b", rv_vec(), ep); end
        tick_model();
        @(posedge w_clk); #1;
        bus.w_d_we = 1'b0;
        @(negedge w_clk);
        total++; if (gnt_vec() !== 3'b001 || bus.w_m_we !== 1'b0) begin bad++; $display("FAIL rd_drive got=%b/%b want=001/0", gnt_vec(), bus.w_m_we); end
        sb_next(ep, ed);
        total++; if (rv_vec() !== ep) begin bad++; $display("FAIL rd_rv0 got=%b want=%b (write must not return data)", rv_vec(), ep); end
        tick_model();
        @(posedge w_clk); #1;
        bus.w_d_req = 1'b0;
        @(negedge w_clk);
        sb_next(ep, ed);
        total++; if (rv_vec() !== ep || (ep != 3'b000 && bus.w_rdata !== ed)) begin bad++; $display("FAIL rd_rv got=%b/%h want=%b/%h", rv_vec(), bus.w_rdata, ep, ed); end
        total++; if (rv_vec() !== 3'b001 || bus.w_rdata !== 32'h00000007) begin bad++; $display("FAIL rd_data got=%b/%h want=001/00000007", rv_vec(), bus.w_rdata); end
        total++; if (bus.w_m_we !== 1'b0) begin bad++; $display("FAIL rd_idle_we got=%b want=0", bus.w_m_we); end
        tick_model();
        @(posedge w_clk); #1;
    endtask

    task automatic test_contention();
        bus.w_d_req = 1'b1; bus.w_d_we = 1'b0; bus.w_d_addr = 12'h100;
        bus.w_i_req = 1'b1; bus.w_i_addr = 12'h200;
        bus.w_l_req = 1'b1; bus.w_l_we = 1'b0; bus.w_l_addr = 12'h300;
        for (int k = 0; k < 24; k++) begin
            @(negedge w_clk);
            eg = model_gnt();
            total++; if (gnt_vec() !== eg) begin bad++; $display("FAIL cont_gnt cyc=%0d got=%b want=%b", k, gnt_vec(), eg); end
            if (k == 8) begin
                total++; if (gnt_vec() !== 3'b010) begin bad++; $display("FAIL cont_i_urgent got=%b want=010", gnt_vec()); end
            end
            if (k == 9) begin
                total++; if (gnt_vec() !== 3'b100) begin bad++; $display("FAIL cont_l_urgent got=%b want=100", gnt_vec()); end
            end
            total++; if (32'(dut.cnt_i) !== mc[1] || 32'(dut.cnt_l) !== mc[2]) begin bad++; $display("FAIL cont_cnt cyc=%0d got=%0d/%0d want=%0d/%0d", k, dut.cnt_i, dut.cnt_l, mc[1], mc[2]); end
            sb_next(ep, ed);
            total++; if (rv_vec() !== ep || (ep != 3'b000 && bus.w_rdata !== ed)) begin bad++; $display("FAIL cont_rv cyc=%0d got=%b/%h want=%b/%h", k, rv_vec(), bus.w_rdata, ep, ed); end
            tick_model();
            @(posedge w_clk); #1;
        end
        idle_inputs();
        @(negedge w_clk);
        sb_next(ep, ed);
        total++; if (rv_vec() !== ep || (ep != 3'b000 && bus.w_rdata !== ed)) begin bad++; $display("FAIL cont_rv_drain got=%b/%h want=%b/%h", rv_vec(), bus.w_rdata, ep, ed); end
        tick_model();
        @(posedge w_clk); #1;
    endtask

    task automatic test_starvation();
        bus.w_d_req = 1'b1; bus.w_d_we = 1'b0; bus.w_d_addr = 12'h0A0;
        bus.w_l_req = 1'b1; bus.w_l_we = 1'b0; bus.w_l_addr = 12'h0B0;
        for (int k = 0; k < 12; k++) begin
            @(negedge w_clk);
            eg = model_gnt();
            total++; if (gnt_vec() !== eg) begin bad++; $display("FAIL starve_gnt cyc=%0d got=%b want=%b", k, gnt_vec(), eg); end
            if (k == 8) begin
                total++; if (bus.w_l_gnt !== 1'b1) begin bad++; $display("FAIL starve_bound got=%b want=1", bus.w_l_gnt); end
            end
            total++; if (32'(dut.cnt_l) !== mc[2]) begin bad++; $display("FAIL starve_cnt cyc=%0d got=%0d want=%0d", k, dut.cnt_l, mc[2]); end
            sb_next(ep, ed);
            total++; if (rv_vec() !== ep || (ep != 3'b000 && bus.w_rdata !== ed)) begin bad++; $display("FAIL starve_rv cyc=%0d got=%b/%h want=%b/%h", k, rv_vec(), bus.w_rdata, ep, ed); end
            tick_model();
            @(posedge w_clk); #1;
        end
        idle_inputs();
        @(negedge w_clk);
        sb_next(ep, ed);
        total++; if (rv_vec() !== ep || (ep != 3'b000 && bus.w_rdata !== ed)) begin bad++; $display("FAIL starve_rv_drain got=%b/%h want=%b/%h", rv_vec(), bus.w_rdata, ep, ed); end
        tick_model();
        @(posedge w_clk); #1;
    endtask

    task automatic test_dropped();
        bus.w_d_req = 1'b1; bus.w_d_we = 1'b0; bus.w_d_addr = 12'h040;
        bus.w_l_req = 1'b1; bus.w_l_we = 1'b1; bus.w_l_addr = 12'h050; bus.w_l_din = 32'hDEADBEEF;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) bus.w_l_req = 1'b0;
            @(negedge w_clk);
            eg = model_gnt();
            total++; if (gnt_vec() !== eg || bus.w_l_gnt !== 1'b0) begin bad++; $display("FAIL drop_gnt cyc=%0d got=%b want=%b", k, gnt_vec(), eg); end
            sb_next(ep, ed);
            total++; if (rv_vec() !== ep || (ep != 3'b000 && bus.w_rdata !== ed)) begin bad++; $display("FAIL drop_rv cyc=%0d got=%b/%h want=%b/%h", k, rv_vec(), bus.w_rdata, ep, ed); end
            tick_model();
            @(posedge w_clk); #1;
        end
        bus.w_d_req = 1'b0;
        @(negedge w_clk);
        total++; if (dut.cnt_l !== 4'd0) begin bad++; $display("FAIL drop_cnt got=%0d want=0", dut.cnt_l); end
        total++; if (gnt_vec() !== 3'b000 || bus.w_m_we !== 1'b0) begin bad++; $display("FAIL drop_idle got=%b/%b want=000/0", gnt_vec(), bus.w_m_we); end
        total++; if (bus.w_m_addr !== m_last || bus.w_m_din !== '0) begin bad++; $display("FAIL drop_park got=%h/%h want=%h/0", bus.w_m_addr, bus.w_m_din, m_last); end
        total++; if (mem[12'h050] !== ref_mem[12'h050]) begin bad++; $display("FAIL drop_no_write got=%h want=%h", mem[12'h050], ref_mem[12'h050]); end
        sb_next(ep, ed);
        total++; if (rv_vec() !== ep || (ep != 3'b000 && bus.w_rdata !== ed)) begin bad++; $display("FAIL drop_rv_drain got=%b/%h want=%b/%h", rv_vec(), bus.w_rdata, ep, ed); end
        tick_model();
        @(posedge w_clk); #1;
    endtask

    task automatic test_async_reset();
        bus.w_i_req = 1'b1; bus.w_i_addr = 12'h020;
        @(negedge w_clk);
        total++; if (gnt_vec() !== 3'b010) begin bad++; $display("FAIL arst_gnt got=%b want=010", gnt_vec()); end
        sb_next(ep, ed);
        tick_model();
        @(posedge w_clk); #1;
        bus.w_i_req = 1'b0;
        bus.w_d_req = 1'b1; bus.w_d_we = 1'b0; bus.w_d_addr = 12'h030;
        sb_next(ep, ed);
        total++; if (rv_vec() !== ep || (ep != 3'b000 && bus.w_rdata !== ed)) begin bad++; $display("FAIL arst_rv_pre got=%b/%h want=%b/%h", rv_vec(), bus.w_rdata, ep, ed); end
        #1 w_rst = 1'b1;
        #1;
        total++; if (bus.r_i_rvalid !== 1'b0) begin bad++; $display("FAIL arst_rv_drop got=%b want=0", bus.r_i_rvalid); end
        total++; if (gnt_vec() !== 3'b000 || bus.w_m_we !== 1'b0) begin bad++; $display("FAIL arst_gnt_off got=%b/%b want=000/0", gnt_vec(), bus.w_m_we); end
        total++; if ({dut.cnt_d, dut.cnt_i, dut.cnt_l} !== 12'h000) begin bad++; $display("FAIL arst_cnt got=%h want=000", {dut.cnt_d, dut.cnt_i, dut.cnt_l}); end
        total++; if (bus.w_m_addr !== 12'h000) begin bad++; $display("FAIL arst_m_addr got=%h want=000", bus.w_m_addr); end
        sbq.delete();
        for (int k = 0; k < 3; k++) mc[k] = 0;
        m_last = '0;
        @(posedge w_clk);
        @(negedge w_clk);
        w_rst = 1'b0;
        #1;
        total++; if (gnt_vec() !== 3'b001) begin bad++; $display("FAIL arst_after_gnt got=%b want=001", gnt_vec()); end
        total++; if (rv_vec() !== 3'b000) begin bad++; $display("FAIL arst_after_rv got=%b want=000", rv_vec()); end
        tick_model();
        @(posedge w_clk); #1;
        bus.w_d_req = 1'b0;
        @(negedge w_clk);
        sb_next(ep, ed);
        total++; if (rv_vec() !== ep || (ep != 3'b000 && bus.w_rdata !== ed)) begin bad++; $display("FAIL arst_after_read got=%b/%h want=%b/%h", rv_vec(), bus.w_rdata, ep, ed); end
        total++; if (bus.r_d_rvalid !== 1'b1 || bus.w_rdata !== init_word(32'h030)) begin bad++; $display("FAIL arst_after_data got=%b/%h want=1/%h", bus.r_d_rvalid, bus.w_rdata, init_word(32'h030)); end
        tick_model();
        @(posedge w_clk); #1;
    endtask

    initial begin
        for (int a = 0; a < int'(DEPTH); a++) ref_mem[a] = init_word(a);
        for (int k = 0; k < 3; k++) mc[k] = 0;
        m_last = '0;
        test_reset();
        test_single_read();
        test_write_read();
        test_contention();
        test_starvation();
        test_dropped();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/m_memarb.md
# m_memarb

Three-port arbiter that shares one synchronous single-port 4K-word memory (1-cycle read latency, write on clock edge) between the pipeline's MEM-stage data port, the IF-stage instruction fetch port and a loader/debug port. It grants at most one access per cycle by fixed priority, promotes starved requesters, and returns a one-cycle read-valid pulse to the port whose read was issued. It sits between the processor core, the loader and a single `m_memory` instance.

## Interface
- ADDR_W, 12, word address width
- DATA_W, 32, data width
- STARVE, 8, consecutive denied cycles after which a requester becomes urgent (1..15)
- w_clk  in  1  clock
- w_rst  in  1  asynchronous reset, active-high
- w_d_req, w_i_req, w_l_req  in  1 each  access request: data, ifetch, loader
- w_d_we, w_l_we  in  1 each  write enable; the ifetch port is read-only
- w_d_addr, w_i_addr, w_l_addr  in  ADDR_W each  word address
- w_d_din, w_l_din  in  DATA_W each  write data
- w_d_gnt, w_i_gnt, w_l_gnt  out  1 each  grant, combinational, one-hot or all zero
- r_d_rvalid, r_i_rvalid, r_l_rvalid  out  1 each  read data valid on w_rdata
- w_rdata  out  DATA_W  read data, wired to w_m_dout
- w_m_addr  out  ADDR_W  memory address
- w_m_we  out  1  memory write enable
- w_m_din  out  DATA_W  memory write data
- w_m_dout  in  DATA_W  memory registered read data

## Operation
- Request rule: a requester holds req, addr, we and din stable until it sees gnt high. The access is performed at the clock edge that ends the grant cycle.
- Base priority: D > I > L.
- Urgency: each port has a 4-bit wait counter.
  - Increments, saturating at STARVE, in each cycle its req is high and its gnt is low.
  - Clears to 0 on grant, or in any cycle its req is low.
  - A port whose counter equals STARVE is urgent.
- Selection:
  - If any requesting port is urgent, grant the highest-base-priority urgent port.
  - Otherwise grant the highest-base-priority requesting port.
  - If no port requests, grant none.
- Memory drive:
  - w_m_addr and w_m_din come from the granted port.
  - w_m_we = granted port's we. It is 0 for the I port and 0 when no port is granted.
  - With no grant, w_m_addr holds the last granted address (registered copy) and w_m_din = 0.
- Read return: if the grant in cycle N is a read, the matching rvalid is high for exactly cycle N+1. Writes produce no rvalid.
- w_rdata always equals w_m_dout. It is meaningful only while an rvalid is high.
- At most one rvalid is high in any cycle.

## Timing
- Grant latency: 0 cycles. gnt is valid in the same cycle as req, after the counters settle.
- Read latency: 1 cycle from grant to rvalid. Back-to-back reads from one or several ports give one rvalid per cycle.
- Write: memory is updated at the edge ending the grant cycle. A read to the same address granted in the next cycle returns the new data.
- Reset (asynchronous, w_rst high):
  - All wait counters = 0, all rvalid = 0, the registered last address = 0.
  - All gnt = 0 and w_m_we = 0 while w_rst is high.
- Reset mid-operation: a read granted in the cycle reset asserts gets no rvalid, and its data is dropped.
- First cycle after reset release: normal arbitration.
- Simultaneous requests with no urgent port: D wins, and I and L counters increment.
- Two urgent ports: the higher base priority wins. The loser stays urgent (saturated) and wins next unless a higher urgent port is present.
- Req dropped before grant: the counter clears and no access occurs.
- Counter saturation: the counter never exceeds STARVE and never wraps.

## Test plan
- Single read: I requests addr 0x005 with mem[5]=0x2014000B. Required: w_i_gnt=1 in the same cycle, then r_i_rvalid=1 for one cycle with w_rdata=0x2014000B; no other gnt or rvalid.
- Write then read: D writes 0x00000007 to 0x010 in cycle N, then reads 0x010 in cycle N+1. Required: w_m_we=1 only in cycle N, and r_d_rvalid in cycle N+2 with w_rdata=0x00000007.
- Contention: D, I and L all request continuously. Required: D granted every cycle until the I counter reaches 8; then I is granted once; then D resumes. L is granted when it becomes urgent and I is not urgent. No rvalid collides.
- Starvation bound: D requests every cycle and L requests continuously (STARVE=8). Required: w_l_gnt=1 no later than the 9th cycle of L's request.
- Idle and dropped request: L raises req for 3 cycles while D requests, then drops it. Required: L counter = 0, no L access occurs, and w_m_we=0 when no port is granted.
- Async reset: assert w_rst between clock edges the cycle after an I read grant. Required: r_i_rvalid goes 0 immediately, all gnt=0, and the counters read 0; after release, a D read completes normally.
